multi_counter_core: RTL and testbench
=====================================

# multi_counter_core

Parametrised multi-channel counter/timer peripheral core. Each of CHANNELS independent counters has:
- configurable width, direction and prescaler;
- a compare/reload register;
- free-running, auto-reload and one-shot modes.

Compare events latch into a shared write-1-to-clear pending register, which drives a single registered interrupt line. The block sits behind the standard peripheral register bus, with flat write enables and one read word per register.

## Interface
- CHANNELS, 4: number of counter channels (1–8).
- WIDTH, 32: counter and compare width (1–32). Upper bus bits are ignored on write and read as 0.
- REGS, 3*CHANNELS+1: register count (derived; do not override).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en  in  REGS  one-hot per-register write strobe, valid for one cycle.
- data_in  in  32  write data, shared by all registers.
- data_out  out  [REGS-1:0][32]  continuous readback of every register.
- irq_out  out  1  registered interrupt request, level.

## Operation
- Register map for channel c: COUNT at 3c, COMPARE at 3c+1, CONFIG at 3c+2. STATUS is at 3*CHANNELS.
- CONFIG bits:
  - [0] en
  - [1] dir (1 = up, 0 = down)
  - [2] ire
  - [4:3] mode (00 free-run, 01 auto-reload, 10 one-shot, 11 treated as 01)
  - [15:8] presc
  - all other bits read 0.
- STATUS bits: [CHANNELS-1:0] pending. Write 1 to clear a bit; writing 0 has no effect. Other bits read 0.
- Prescaler: per-channel counter pc. tick = en && (pc == presc). When en, pc_next = tick ? 0 : pc+1; when !en, pc_next = 0. A COUNT or CONFIG write to the channel forces pc_next = 0. The counter steps only on tick, i.e. once every presc+1 cycles.
- Target value: up = COMPARE; down = 0 in modes 01/10, COMPARE in mode 00.
- event = tick && (count == target).
- Step on tick, no event: count ± 1, modulo 2^WIDTH.
- Step on tick with event:
  - mode 00: normal step (wraps), pending set.
  - mode 01: reload (up → 0, down → COMPARE), pending set.
  - mode 10: reload as mode 01, en cleared, pending set.
- COUNT write: count_next = data_in[WIDTH-1:0]. It overrides any step that cycle, and no event fires that cycle.
- CONFIG write: all fields load from data_in. It wins over a one-shot en clear in the same cycle. The step that cycle uses the old (registered) config.
- COMPARE write: takes effect for comparisons from the next cycle.
- pending[c] is set on an event regardless of ire. If set and clear hit the same cycle, set wins.
- irq_next = |(pending & ire_vector). irq_out is the registered irq_next.
- WIDTH < 32: readback is zero-extended and write data is truncated.

## Timing
- Reset: every count, COMPARE, CONFIG, pc, pending and irq_out is 0. data_out is all zeros from the first cycle after reset.
- Reset asserted mid-operation clears all state at that edge, including pending interrupts and prescaler phase.
- A write is visible on data_out one cycle after its strobe cycle.
- Counter step: count updates at the edge where tick = 1 and is visible on data_out one cycle later.
- Event at edge N: pending visible at N+1; irq_out asserts at edge N+1, visible N+2.
- Clearing pending (or clearing ire) at edge N: irq_out deasserts at edge N+1.
- irq_out stays high while any enabled channel has its pending bit set.

## Configuration
- PRESCALER_EN:
  - Defined: per-channel 8-bit prescaler as described; CONFIG[15:8] is writable and reads back.
  - Undefined: no pc registers; tick = en every cycle; CONFIG[15:8] is ignored on write and reads 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset/readback: hold reset 2 cycles, then write COUNT0=0x1234, COMPARE0=0x55, CONFIG0=0x0 → data_out[0]=0x1234 and data_out[1]=0x55 one cycle later; all other words and irq_out stay 0.
- Auto-reload up with irq: COMPARE0=3, CONFIG0=0x0F (en, up, ire, mode 01), COUNT0=0 → count sequence 0,1,2,3,0,1…; pending[0] set when 3→0; irq_out high 2 cycles after the event edge; write STATUS=0x1 → irq_out low one cycle later.
- One-shot down with prescaler (PRESCALER_EN): COMPARE1=5, COUNT1=2, CONFIG1=0x0111 (en, down, mode 10, presc=1) → count steps every 2 cycles 2,1,0,5, then holds; CONFIG1[0] reads 0; pending[1]=1; irq_out stays 0 because ire=0.
- Free-run wrap, WIDTH=8: COUNT0=0xFE, CONFIG0=0x3 (en, up, mode 00), COMPARE0=0xFF → count 0xFE, 0xFF, 0x00, 0x01; pending[0] set on the 0xFF→0x00 step; no reload.
- Simultaneous events: a STATUS clear of bit 0 in the same cycle as a new channel-0 event → pending[0] remains 1. A COUNT0 write in the cycle where count==COMPARE → write value loaded and no event.
- Mid-operation reset: counters running with irq_out=1, assert reset for 1 cycle → all data_out words and irq_out are 0 on the next cycle; counters stay stopped.

Source files
------------

// File: rtl/multi_counter_core.sv
// multi_counter_core: multi-channel counter/timer core behind a flat register bus.
// Register map per channel c: COUNT at 3c, COMPARE at 3c+1, CONFIG at 3c+2.
// STATUS (write-1-to-clear pending bits) is at 3*CHANNELS.
// Optional feature macro: PRESCALER_EN adds an 8-bit per-channel prescaler (CONFIG[15:8]).

package mcc_pkg;
   typedef struct packed {
      logic [7:0] presc;
      logic [1:0] mode;
      logic       ire;
      logic       dir;
      logic       en;
   } cfg_t;
endpackage

// One counter channel: count/compare/config state, tick generation and event detect.
module mcc_chan
   import mcc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic        wr_config,
   input  logic [31:0] data_in,
   output logic [31:0] count_rd,
   output logic [31:0] compare_rd,
   output logic [31:0] config_rd,
   output logic        ire,
   output logic        evt
);

   logic [WIDTH-1:0] count, count_nxt, compare, target;
   cfg_t             cfg, cfg_wr;
   logic             tick, reload;

   // Decode a CONFIG write; presc only exists in the prescaler build.
   always_comb begin
      cfg_wr.en    = data_in[0];
      cfg_wr.dir   = data_in[1];
      cfg_wr.ire   = data_in[2];
      cfg_wr.mode  = data_in[4:3];
`ifdef PRESCALER_EN
      cfg_wr.presc = data_in[15:8];
`else
      cfg_wr.presc = '0;
`endif
   end

`ifdef PRESCALER_EN
   logic [7:0] pc;

   assign tick = cfg.en && (pc == cfg.presc);

   // Prescaler phase: restarts on any COUNT/CONFIG write or while disabled.
   always_ff @(posedge clk) begin
      if (reset || wr_count || wr_config || !cfg.en || tick)
         pc <= '0;
      else
         pc <= pc + 8'd1;
   end
`else
   assign tick = cfg.en;
`endif

   // Target, event and next count; a COUNT write overrides the step and suppresses the event.
   always_comb begin
      target    = (cfg.dir || cfg.mode == 2'b00) ? compare : '0;
      evt       = tick && !wr_count && (count == target);
      reload    = evt && (cfg.mode != 2'b00);
      count_nxt = count;
      if (wr_count)
         count_nxt = data_in[WIDTH-1:0];
      else if (reload)
         count_nxt = cfg.dir ? '0 : compare;
      else if (tick)
         count_nxt = cfg.dir ? count + WIDTH'(1) : count - WIDTH'(1);
   end

   // Channel state; a CONFIG write beats the one-shot enable clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         cfg     <= '0;
      end else begin
         count <= count_nxt;
         if (wr_compare)
            compare <= data_in[WIDTH-1:0];
         if (wr_config)
            cfg <= cfg_wr;
         else if (evt && cfg.mode == 2'b10)
            cfg.en <= 1'b0;
      end
   end

   // Zero-extended readback.
   always_comb begin
      count_rd               = '0;
      count_rd[WIDTH-1:0]    = count;
      compare_rd             = '0;
      compare_rd[WIDTH-1:0]  = compare;
      config_rd              = '0;
      config_rd[15:8]        = cfg.presc;
      config_rd[4:0]         = {cfg.mode, cfg.ire, cfg.dir, cfg.en};
   end

   assign ire = cfg.ire;

endmodule

// Top: channel array, shared pending register and registered interrupt.
module multi_counter_core #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int REGS     = 3*CHANNELS+1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REGS-1:0]       write_en,
   input  logic [31:0]           data_in,
   output logic [REGS-1:0][31:0] data_out,
   output logic                  irq_out
);

   localparam int STATUS = 3*CHANNELS;

   logic [CHANNELS-1:0][31:0] cnt_rd, cmp_rd, cfg_rd;
   logic [CHANNELS-1:0]       pending, evt_v, ire_v, clr;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      mcc_chan #(.WIDTH(WIDTH)) u_chan (
         .clk        (clk),
         .reset      (reset),
         .wr_count   (write_en[3*c]),
         .wr_compare (write_en[3*c+1]),
         .wr_config  (write_en[3*c+2]),
         .data_in    (data_in),
         .count_rd   (cnt_rd[c]),
         .compare_rd (cmp_rd[c]),
         .config_rd  (cfg_rd[c]),
         .ire        (ire_v[c]),
         .evt        (evt_v[c])
      );
   end

   assign clr = write_en[STATUS] ? data_in[CHANNELS-1:0] : '0;

   // Pending bits: set beats clear; irq follows the registered pending & ire.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         irq_out <= 1'b0;
      end else begin
         pending <= (pending & ~clr) | evt_v;
         irq_out <= |(pending & ire_v);
      end
   end

   // Assemble the readback words.
   always_comb begin
      data_out = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         data_out[3*c]   = cnt_rd[c];
         data_out[3*c+1] = cmp_rd[c];
         data_out[3*c+2] = cfg_rd[c];
      end
      data_out[STATUS][CHANNELS-1:0] = pending;
   end

endmodule

// File: tb/tb_multi_counter_core.sv
// tb_multi_counter_core: directed checks for multi_counter_core (CHANNELS=4, WIDTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_counter_core;

   localparam int CH   = 4;
   localparam int W    = 16;
   localparam int REGS = 3*CH+1;
   localparam int ST   = 3*CH;

`ifdef PRESCALER_EN
   localparam int          PSTEP   = 2;
   localparam logic [31:0] CFG1_RD = 32'h0111;
   localparam logic [31:0] CFG2_RD = 32'hFF1F;
`else
   localparam int          PSTEP   = 1;
   localparam logic [31:0] CFG1_RD = 32'h0011;
   localparam logic [31:0] CFG2_RD = 32'h001F;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic [REGS-1:0]       we;
   logic [31:0]           din;
   logic [REGS-1:0][31:0] dout;
   logic                  irq;

   int n_chk  = 0;
   int n_fail = 0;

   multi_counter_core #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .write_en (we),
      .data_in  (din),
      .data_out (dout),
      .irq_out  (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input int idx, input logic [31:0] d);
      we      = '0;
      we[idx] = 1'b1;
      din     = d;
      @(negedge clk);
      we  = '0;
      din = '0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [31:0] or_all(input logic [REGS-1:0][31:0] v);
      logic [31:0] r = '0;
      for (int i = 0; i < REGS; i++) r |= v[i];
      return r;
   endfunction

   initial begin
      logic [31:0] others;
      reset = 1'b1;
      we    = '0;
      din   = '0;
      cyc(2);
      reset = 1'b0;
      chk("rst_words", or_all(dout), 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);

      // readback, with write truncation to WIDTH
      wr(0, 32'hABCD1234);
      chk("rb_count0", dout[0], 32'h1234);
      wr(1, 32'h55);
      chk("rb_cmp0", dout[1], 32'h55);
      wr(2, 32'h0);
      others = '0;
      for (int i = 2; i < REGS; i++) others |= dout[i];
      chk("rb_others", others, 32'h0);
      chk("rb_irq", {31'b0, irq}, 32'h0);

      // auto-reload up with interrupt
      wr(1, 3);
      wr(0, 0);
      wr(2, 32'h0F);
      chk("ar_c0", dout[0], 0);
      cyc(1); chk("ar_c1", dout[0], 1);
      cyc(1); chk("ar_c2", dout[0], 2);
      cyc(1); chk("ar_c3", dout[0], 3);
      chk("ar_pend_pre", dout[ST], 0);
      cyc(1); chk("ar_reload", dout[0], 0);
      chk("ar_pend", dout[ST], 1);
      chk("ar_irq_lag", {31'b0, irq}, 0);
      cyc(1); chk("ar_irq", {31'b0, irq}, 1);
      chk("ar_c1b", dout[0], 1);
      wr(ST, 1);
      chk("clr_pend", dout[ST], 0);
      chk("clr_irq_lag", {31'b0, irq}, 1);
      cyc(1); chk("clr_irq", {31'b0, irq}, 0);
      chk("ar_c3b", dout[0], 3);

      // clear in the same cycle as a new event: set wins
      wr(ST, 1);
      chk("setwin_pend", dout[ST], 1);
      chk("setwin_c", dout[0], 0);
      wr(ST, 1);
      chk("setwin_clr", dout[ST], 0);
      cyc(2);
      chk("cw_pre", dout[0], 3);
      // COUNT write while count==COMPARE: loads, no event
      wr(0, 32'h10);
      chk("cw_load", dout[0], 32'h10);
      chk("cw_noevt", dout[ST], 0);
      wr(2, 0);

      // one-shot down on channel 1
      wr(4, 5);
      wr(3, 2);
      wr(5, 32'h0111);
      chk("os_cfg", dout[5], CFG1_RD);
      chk("os_c2", dout[3], 2);
      cyc(PSTEP); chk("os_c1", dout[3], 1);
      cyc(PSTEP); chk("os_c0", dout[3], 0);
      cyc(PSTEP); chk("os_reload", dout[3], 5);
      chk("os_en_clr", dout[5], CFG1_RD & ~32'h1);
      chk("os_pend", dout[ST], 32'h2);
      cyc(4); chk("os_hold", dout[3], 5);
      chk("os_irq", {31'b0, irq}, 0);

      // free-run wrap at WIDTH=16
      wr(ST, 2);
      wr(0, 32'hFFFE);
      wr(1, 32'hFFFF);
      wr(2, 32'h3);
      chk("fr_fe", dout[0], 32'hFFFE);
      cyc(1); chk("fr_ff", dout[0], 32'hFFFF);
      chk("fr_pend0", dout[ST], 0);
      cyc(1); chk("fr_wrap", dout[0], 32'h0);
      chk("fr_pend1", dout[ST], 1);
      cyc(1); chk("fr_01", dout[0], 32'h1);

      // CONFIG unused bits read 0; enable irq on pending channel 0
      wr(8, 32'hFFFFFFFF);
      chk("cfg_mask", dout[8], CFG2_RD);
      wr(2, 32'h07);
      cyc(1); chk("mr_irq", {31'b0, irq}, 1);

      // mid-operation reset
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("mr_words", or_all(dout), 32'h0);
      chk("mr_irq0", {31'b0, irq}, 0);
      cyc(3);
      chk("mr_stopped", or_all(dout), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
